// File: rtl/array_mp_pkg.sv
// Shared types and helpers for the multi-channel array memory and its arbiter.
package array_mp_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_CH     = 2;

    // What the granted channel does to the shared array on the closing edge.
    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_WRITE,
        ACC_READ,
        ACC_OOR
    } access_e;

    // Width of an index into n channels; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (base + off) mod n for base < n and off <= n.
    function automatic int wrap_inc(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/array_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter
    import array_mp_pkg::*;
#(
    parameter int N = DEFAULT_CH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    localparam int PTR_W = idx_width(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] idx;

    // NOTE: every variable gets a default before the search so no path can infer a latch.
    always_comb begin
        gnt      = '0;
        any      = 1'b0;
        ptr_next = ptr;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'(wrap_inc(int'(ptr), k, N));
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
                ptr_next = PTR_W'(wrap_inc(int'(idx), 1, N));
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/array_mp.sv
// Shared DEPTH x DATA_W array serving CH clients, one round-robin access per clock.
// The response bus is named dout because "do" is a reserved word.
module array_mp
    import array_mp_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int CH     = DEFAULT_CH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH*ADDR_W-1:0] addr,
    input  logic [CH-1:0]        we,
    input  logic [CH*DATA_W-1:0] di,
    input  logic [CH-1:0]        valid,
    output logic [CH-1:0]        ready,
    output logic [CH*DATA_W-1:0] dout
);

    localparam int IDX_W = idx_width(CH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CH-1:0]     eligible;
    logic [CH-1:0]     gnt;
    logic              any;
    logic [IDX_W-1:0]  sel_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_di;
    access_e           acc;

    // A channel completing this cycle is masked so its still-held request is not served twice.
    assign eligible = valid & ~ready;

    rr_arbiter #(
        .N(CH)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (eligible),
        .gnt (gnt),
        .any (any)
    );

    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_we   = 1'b0;
        sel_di   = '0;
        for (int i = 0; i < CH; i++) begin
            if (gnt[i]) begin
                sel_idx  = IDX_W'(i);
                sel_addr = addr[i*ADDR_W +: ADDR_W];
                sel_we   = we[i];
                sel_di   = di[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        acc = ACC_IDLE;
        if (any) begin
            if (int'(sel_addr) >= DEPTH) begin
                acc = ACC_OOR;
            end else if (sel_we) begin
                acc = ACC_WRITE;
            end else begin
                acc = ACC_READ;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (acc == ACC_WRITE && !rst) begin
            mem[sel_addr] <= sel_di;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= '0;
            dout  <= '0;
        end else begin
            ready <= gnt;
            case (acc)
                ACC_WRITE: dout[int'(sel_idx)*DATA_W +: DATA_W] <= sel_di;
                ACC_READ:  dout[int'(sel_idx)*DATA_W +: DATA_W] <= mem[sel_addr];
                ACC_OOR:   dout[int'(sel_idx)*DATA_W +: DATA_W] <= '0;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_array_mp.sv
// Directed self-checking bench: a 2-channel DEPTH=200 instance and a 4-channel instance.
module tb_array_mp;

    localparam int DW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [2*AW-1:0] a_addr;
    logic [1:0]      a_we;
    logic [2*DW-1:0] a_di;
    logic [1:0]      a_valid;
    logic [1:0]      a_ready;
    logic [2*DW-1:0] a_dout;

    logic [4*AW-1:0] b_addr;
    logic [3:0]      b_we;
    logic [4*DW-1:0] b_di;
    logic [3:0]      b_valid;
    logic [3:0]      b_ready;
    logic [4*DW-1:0] b_dout;

    array_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .CH(2)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .addr  (a_addr),
        .we    (a_we),
        .di    (a_di),
        .valid (a_valid),
        .ready (a_ready),
        .dout  (a_dout)
    );

    array_mp #(.DATA_W(DW), .ADDR_W(AW), .CH(4)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .addr  (b_addr),
        .we    (b_we),
        .di    (b_di),
        .valid (b_valid),
        .ready (b_ready),
        .dout  (b_dout)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int ch, input logic w, input logic [7:0] ad, input logic [7:0] d);
        a_we[ch]              = w;
        a_addr[ch*AW +: AW]   = ad;
        a_di[ch*DW +: DW]     = d;
        a_valid[ch]           = 1'b1;
    endtask

    // One isolated transaction on instance A: request, one-cycle ready pulse, idle again.
    task automatic a_single(input string tag, input int ch, input logic w,
                            input logic [7:0] ad, input logic [7:0] d, input logic [7:0] exp);
        set_a(ch, w, ad, d);
        step();
        check({tag, "_rdy"}, 32'(a_ready), 32'(1 << ch));
        check({tag, "_do"}, 32'(a_dout[ch*DW +: DW]), 32'(exp));
        a_valid[ch] = 1'b0;
        step();
        check({tag, "_idle"}, 32'(a_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [4];
        int b2b;
        logic [3:0] prev;

        rst     = 1'b1;
        a_addr  = '0; a_we = '0; a_di = '0; a_valid = '0;
        b_addr  = '0; b_we = '0; b_di = '0; b_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_a_dout",  32'(a_dout),  32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_b_dout",  32'(b_dout),  32'd0);
        rst = 1'b0;

        // Contention from pointer 0: ch0 writes 5<-7, ch1 reads 5 one cycle later.
        set_a(0, 1'b1, 8'd5, 8'd7);
        set_a(1, 1'b0, 8'd5, 8'd0);
        step();
        check("t2_rdy_ch0", 32'(a_ready), 32'b01);
        check("t2_do0",     32'(a_dout[0 +: DW]), 32'd7);
        a_valid[0] = 1'b0;
        step();
        check("t2_rdy_ch1", 32'(a_ready), 32'b10);
        check("t2_do1",     32'(a_dout[DW +: DW]), 32'd7);
        a_valid[1] = 1'b0;
        step();
        check("t2_idle", 32'(a_ready), 32'd0);

        // Single client write then read back.
        a_single("t1_wr", 0, 1'b1, 8'd3, 8'd42, 8'd42);
        a_single("t1_rd", 0, 1'b0, 8'd3, 8'd0,  8'd42);

        // Request held through its ready cycle completes once; next request completes normally.
        set_a(0, 1'b0, 8'd3, 8'd0);
        step();
        check("t6_rdy",      32'(a_ready), 32'b01);
        check("t6_do",       32'(a_dout[0 +: DW]), 32'd42);
        step();
        check("t6_no_double", 32'(a_ready), 32'd0);
        check("t6_do_held",   32'(a_dout[0 +: DW]), 32'd42);
        set_a(0, 1'b1, 8'd10, 8'h55);
        step();
        check("t6_next_rdy", 32'(a_ready), 32'b01);
        check("t6_next_do",  32'(a_dout[0 +: DW]), 32'h55);
        a_valid[0] = 1'b0;
        step();
        check("t6_idle", 32'(a_ready), 32'd0);

        // Out-of-range addresses with DEPTH=200, and the last valid word.
        a_single("t4_wr250", 0, 1'b1, 8'd250, 8'd9,  8'd0);
        a_single("t4_rd250", 0, 1'b0, 8'd250, 8'd0,  8'd0);
        a_single("t4_wr199", 0, 1'b1, 8'd199, 8'd11, 8'd11);
        a_single("t4_rd199", 0, 1'b0, 8'd199, 8'd0,  8'd11);
        a_single("t4_rd3",   0, 1'b0, 8'd3,   8'd0,  8'd42);

        // Reset while a ch1 read is granted (pointer currently 1).
        set_a(1, 1'b0, 8'd5, 8'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_ready", 32'(a_ready), 32'd0);
        check("t5_async_dout",  32'(a_dout),  32'd0);
        step();
        check("t5_hold_ready", 32'(a_ready), 32'd0);
        check("t5_hold_dout",  32'(a_dout),  32'd0);
        rst        = 1'b0;
        a_valid[1] = 1'b0;
        step();
        check("t5_post_ready", 32'(a_ready), 32'd0);
        // Pointer back at 0: ch0 wins, and memory kept its pre-reset contents.
        set_a(0, 1'b0, 8'd3, 8'd0);
        set_a(1, 1'b0, 8'd5, 8'd0);
        step();
        check("t5_rdy_ch0", 32'(a_ready), 32'b01);
        check("t5_do0",     32'(a_dout[0 +: DW]), 32'd42);
        a_valid[0] = 1'b0;
        step();
        check("t5_rdy_ch1", 32'(a_ready), 32'b10);
        check("t5_do1",     32'(a_dout[DW +: DW]), 32'd7);
        a_valid[1] = 1'b0;
        step();
        check("t5_idle", 32'(a_ready), 32'd0);

        // Fairness on four channels all requesting for 16 cycles.
        for (int c = 0; c < 4; c++) begin
            b_we[c]            = 1'b1;
            b_addr[c*AW +: AW] = 8'(c);
            b_di[c*DW +: DW]   = 8'(8'h10 + c);
            b_valid[c]         = 1'b1;
            cnt[c]             = 0;
        end
        b2b  = 0;
        prev = '0;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("t3_gnt%0d", k), 32'(b_ready), 32'(4'b0001 << (k % 4)));
            check($sformatf("t3_do%0d", k), 32'(b_dout[(k % 4)*DW +: DW]), 32'(8'h10 + (k % 4)));
            for (int c = 0; c < 4; c++) begin
                if (b_ready[c]) begin
                    cnt[c]++;
                    if (prev[c]) b2b++;
                end
            end
            prev = b_ready;
        end
        b_valid = '0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("t3_count_ch%0d", c), 32'(cnt[c]), 32'd4);
        end
        check("t3_back_to_back", 32'(b2b), 32'd0);
        step();
        check("t3_idle", 32'(b_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
